// File: rtl/l2_mshr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_mshr_sched_pkg
// Description : Shared constants and helpers for the L2 MSHR scheduler.
//               Provides the default MSHR pool size and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_mshr_sched_pkg;

    // Default number of MSHR entries in the L2 pool.
    localparam int unsigned c_NUM_MSHR_DEF = 4;

    // Width of an index that addresses n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : l2_mshr_sched_pkg
`default_nettype wire

// File: rtl/l2_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : l2_rr_arb
// Description : Round-robin arbiter with a grant lock. Search begins at the
//               round-robin pointer. While the selected request waits for
//               ready, the selection is frozen until it is accepted.
// Ports       : clk, rst_n        clock, async active-low reset
//               req_i   [N]       request vector (already masked by caller)
//               ready_i           downstream ready
//               valid_o           selected request is asserted
//               idx_o   [IDX_W]   selected request index
//               gnt_o   [N]       one-hot grant (ready & valid)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_rr_arb
    import l2_mshr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = c_NUM_MSHR_DEF,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [IDX_W-1:0] r_ptr;
    logic             r_lock;
    logic [IDX_W-1:0] r_held;

    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    logic             w_fire;

    // Rotating search from r_ptr. NUM_REQ is a power of two, so the index
    // addition wraps naturally in IDX_W bits.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        w_pick  = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // A locked selection stays put; its valid follows the held requester.
    assign valid_o = r_lock ? req_i[r_held] : w_found;
    assign idx_o   = r_lock ? r_held : w_pick;
    assign w_fire  = valid_o & ready_i;

    always_comb begin
        gnt_o = '0;
        if (w_fire) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_lock <= 1'b0;
            r_held <= '0;
        end else if (w_fire) begin
            r_ptr  <= idx_o + IDX_W'(1);
            r_lock <= 1'b0;
        end else if (valid_o) begin
            r_lock <= 1'b1;
            r_held <= idx_o;
        end
    end

endmodule : l2_rr_arb
`default_nettype wire

// File: rtl/l2_mshr_sched.sv
`default_nettype none
// ============================================================================
// Module      : l2_mshr_sched
// Description : L2 MSHR pool owner. Allocates the lowest free entry to each
//               miss, arbitrates per-entry refill (a) and core-response (d)
//               requests onto single channels, and frees an entry when its d
//               response is accepted.
// Ports       : clk, rst_n                 clock, async active-low reset
//               alloc_req_i / alloc_ready_o / alloc_idx_o / alloc_vec_o
//                                          allocation handshake and strobe
//               mshr_valid_o               entry-occupied bits
//               a_req_i/a_gnt_o/a_valid_o/a_ready_i/a_idx_o   a channel
//               d_req_i/d_gnt_o/d_valid_o/d_ready_i/d_idx_o   d channel
//               count_o, full_o, empty_o   occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mshr_sched
    import l2_mshr_sched_pkg::*;
#(
    parameter int unsigned NUM_MSHR = c_NUM_MSHR_DEF,
    parameter int unsigned IDX_W    = idx_width(NUM_MSHR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req_i,
    output logic                alloc_ready_o,
    output logic [IDX_W-1:0]    alloc_idx_o,
    output logic [NUM_MSHR-1:0] alloc_vec_o,
    output logic [NUM_MSHR-1:0] mshr_valid_o,
    input  logic [NUM_MSHR-1:0] a_req_i,
    output logic [NUM_MSHR-1:0] a_gnt_o,
    output logic                a_valid_o,
    input  logic                a_ready_i,
    output logic [IDX_W-1:0]    a_idx_o,
    input  logic [NUM_MSHR-1:0] d_req_i,
    output logic [NUM_MSHR-1:0] d_gnt_o,
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [IDX_W-1:0]    d_idx_o,
    output logic [IDX_W:0]      count_o,
    output logic                full_o,
    output logic                empty_o
);

    logic [NUM_MSHR-1:0] r_valid;
    logic [IDX_W:0]      r_count;

    logic [IDX_W-1:0]    w_free_idx;
    logic                w_any_free;
    logic                w_alloc_fire;
    logic                w_d_fire;
    logic [NUM_MSHR-1:0] w_clr_vec;

    // Lowest free entry, from registered valid bits only: an entry released
    // this cycle is still marked valid here, so it is not handed out until
    // the following cycle.
    always_comb begin
        w_free_idx = '0;
        w_any_free = 1'b0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign alloc_ready_o = w_any_free;
    assign alloc_idx_o   = w_free_idx;
    assign w_alloc_fire  = alloc_req_i & w_any_free;

    always_comb begin
        alloc_vec_o = '0;
        if (w_alloc_fire) begin
            alloc_vec_o[w_free_idx] = 1'b1;
        end
    end

    // Requests from unoccupied entries are ignored by both arbiters.
    l2_rr_arb #(
        .NUM_REQ (NUM_MSHR),
        .IDX_W   (IDX_W)
    ) u_arb_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (a_req_i & r_valid),
        .ready_i (a_ready_i),
        .valid_o (a_valid_o),
        .idx_o   (a_idx_o),
        .gnt_o   (a_gnt_o)
    );

    l2_rr_arb #(
        .NUM_REQ (NUM_MSHR),
        .IDX_W   (IDX_W)
    ) u_arb_d (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (d_req_i & r_valid),
        .ready_i (d_ready_i),
        .valid_o (d_valid_o),
        .idx_o   (d_idx_o),
        .gnt_o   (d_gnt_o)
    );

    assign w_d_fire  = d_valid_o & d_ready_i;
    assign w_clr_vec = d_gnt_o;

    // Allocation always targets a free entry and release a valid one, so the
    // set and clear vectors never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= (r_valid | alloc_vec_o) & ~w_clr_vec;
            case ({w_alloc_fire, w_d_fire})
                2'b10:   r_count <= r_count + (IDX_W+1)'(1);
                2'b01:   r_count <= r_count - (IDX_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign mshr_valid_o = r_valid;
    assign count_o      = r_count;
    assign full_o       = (r_count == (IDX_W+1)'(NUM_MSHR));
    assign empty_o      = (r_count == '0);

    a_d_fire_valid : assert property (@(posedge clk) disable iff (!rst_n)
        w_d_fire |-> r_valid[d_idx_o]);
    a_alloc_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(alloc_vec_o));
    a_agnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(a_gnt_o));
    a_dgnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(d_gnt_o));
    a_cnt_no_over : assert property (@(posedge clk) disable iff (!rst_n)
        !(full_o && w_alloc_fire && !w_d_fire));
    a_cnt_no_under : assert property (@(posedge clk) disable iff (!rst_n)
        !(empty_o && w_d_fire && !w_alloc_fire));

endmodule : l2_mshr_sched
`default_nettype wire

// File: tb/tb_l2_mshr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mshr_sched
// Description : Self-checking bench for l2_mshr_sched. A behavioural model of
//               the MSHR pool and both channel arbiters is compared against
//               the DUT every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mshr_sched;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_ready;
    logic [1:0] alloc_idx;
    logic [3:0] alloc_vec;
    logic [3:0] mshr_valid;
    logic [3:0] a_req;
    logic [3:0] a_gnt;
    logic       a_valid;
    logic       a_ready;
    logic [1:0] a_idx;
    logic [3:0] d_req;
    logic [3:0] d_gnt;
    logic       d_valid;
    logic       d_ready;
    logic [1:0] d_idx;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;

    l2_mshr_sched #(.NUM_MSHR(4), .IDX_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req_i   (alloc_req),
        .alloc_ready_o (alloc_ready),
        .alloc_idx_o   (alloc_idx),
        .alloc_vec_o   (alloc_vec),
        .mshr_valid_o  (mshr_valid),
        .a_req_i       (a_req),
        .a_gnt_o       (a_gnt),
        .a_valid_o     (a_valid),
        .a_ready_i     (a_ready),
        .a_idx_o       (a_idx),
        .d_req_i       (d_req),
        .d_gnt_o       (d_gnt),
        .d_valid_o     (d_valid),
        .d_ready_i     (d_ready),
        .d_idx_o       (d_idx),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pool: set of occupied entries. Each channel (0=a, 1=d): a rotating
    // priority start and an optional "held" entry awaiting acceptance.
    logic [3:0] m_valid;
    int         m_ptr  [2];
    bit         m_lock [2];
    int         m_held [2];
    logic [3:0] n_valid;
    int         n_ptr  [2];
    bit         n_lock [2];
    int         n_held [2];

    task automatic model_reset();
        m_valid = '0;
        for (int c = 0; c < 2; c++) begin
            m_ptr[c] = 0; m_lock[c] = 0; m_held[c] = 0;
        end
    endtask

    function automatic int first_free(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return -1;
    endfunction

    task automatic rr_pick(input logic [3:0] req, input int ch, output int idx, output bit val);
        idx = 0;
        val = 0;
        if (m_lock[ch]) begin
            idx = m_held[ch];
            val = req[idx];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr[ch] + k) % 4;
                if (!val && req[j]) begin
                    idx = j;
                    val = 1;
                end
            end
        end
    endtask

    task automatic channel(input string nm, input int ch, input logic [3:0] req,
                           input logic rdy, input logic act_v, input logic [1:0] act_i,
                           input logic [3:0] act_g, output bit fire, output int idx);
        bit         val;
        logic [3:0] eg;
        rr_pick(req & m_valid, ch, idx, val);
        fire = val && rdy;
        eg   = '0;
        if (fire) eg[idx] = 1'b1;
        chk({nm, "_valid"}, act_v, val);
        if (val) chk({nm, "_idx"}, act_i, idx);
        chk({nm, "_gnt"}, act_g, eg);
        n_ptr[ch]  = m_ptr[ch];
        n_lock[ch] = m_lock[ch];
        n_held[ch] = m_held[ch];
        if (fire) begin
            n_ptr[ch]  = (idx + 1) % 4;
            n_lock[ch] = 0;
        end else if (val) begin
            n_lock[ch] = 1;
            n_held[ch] = idx;
        end
    endtask

    task automatic model_check();
        int         ff, ia, id;
        bit         rdy, afire, af, df;
        logic [3:0] ev;
        ff    = first_free(m_valid);
        rdy   = (ff >= 0);
        afire = alloc_req && rdy;
        ev    = '0;
        if (afire) ev[ff] = 1'b1;
        chk("alloc_ready", alloc_ready, rdy);
        if (rdy) chk("alloc_idx", alloc_idx, ff);
        chk("alloc_vec", alloc_vec, ev);
        chk("mshr_valid", mshr_valid, m_valid);
        chk("count", count, $countones(m_valid));
        chk("full", full, m_valid == 4'hF);
        chk("empty", empty, m_valid == 4'h0);
        channel("a", 0, a_req, a_ready, a_valid, a_idx, a_gnt, af, ia);
        channel("d", 1, d_req, d_ready, d_valid, d_idx, d_gnt, df, id);
        n_valid = m_valid | ev;
        if (df) n_valid[id] = 1'b0;
    endtask

    // Compare process: checks at every falling edge out of reset, commits the
    // model at the following rising edge, and resets with the DUT.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_check();
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    model_reset();
                end else begin
                    m_valid = n_valid;
                    for (int c = 0; c < 2; c++) begin
                        m_ptr[c] = n_ptr[c]; m_lock[c] = n_lock[c]; m_held[c] = n_held[c];
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic al, input logic [3:0] ar, input logic ardy,
                       input logic [3:0] dr, input logic drdy);
        @(posedge clk);
        #1;
        alloc_req = al; a_req = ar; a_ready = ardy; d_req = dr; d_ready = drdy;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_aready"}, alloc_ready, 1);
        chk({tag, "_aidx"}, alloc_idx, 0);
        chk({tag, "_valid"}, mshr_valid, 0);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_a_gnt"}, a_gnt, 0);
        chk({tag, "_d_valid"}, d_valid, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_req = 0; a_req = '0; a_ready = 0; d_req = '0; d_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk_reset_vals("rst");

        // 1: four back-to-back allocations, then refusal when full
        for (int k = 0; k < 4; k++) begin
            cyc(1, 4'h0, 0, 4'h0, 0);
            chk("t1_idx", alloc_idx, k);
            chk("t1_vec", alloc_vec, 4'b0001 << k);
        end
        cyc(1, 4'h0, 0, 4'h0, 0);
        chk("t1_ready5", alloc_ready, 0);
        chk("t1_full", full, 1);
        chk("t1_count", count, 4);

        // 2: round-robin with wrap
        cyc(0, 4'b1011, 1, 4'h0, 0); chk("t2_g0", a_gnt, 4'b0001);
        cyc(0, 4'b1011, 1, 4'h0, 0); chk("t2_g1", a_gnt, 4'b0010);
        cyc(0, 4'b1011, 1, 4'h0, 0); chk("t2_g2", a_gnt, 4'b1000);
        cyc(0, 4'b1011, 1, 4'h0, 0); chk("t2_g3", a_gnt, 4'b0001);

        // 3: held grant while ready is low, single fire
        for (int k = 0; k < 3; k++) begin
            cyc(0, 4'b0110, 0, 4'h0, 0);
            chk("t3_idx", a_idx, 1);
            chk("t3_gnt", a_gnt, 0);
        end
        cyc(0, 4'b0110, 1, 4'h0, 0);
        chk("t3_fire", a_gnt, 4'b0010);

        // 4: release while full blocks same-cycle reallocation
        cyc(1, 4'h0, 0, 4'b0100, 1);
        chk("t4_refuse", alloc_ready, 0);
        chk("t4_dgnt", d_gnt, 4'b0100);
        cyc(1, 4'h0, 0, 4'h0, 0);
        chk("t4_ready", alloc_ready, 1);
        chk("t4_idx", alloc_idx, 2);

        // 5: simultaneous alloc and release at count 2
        cyc(0, 4'h0, 0, 4'b0001, 1); chk("t5_d0", d_idx, 0);
        cyc(0, 4'h0, 0, 4'b0010, 1); chk("t5_d1", d_idx, 1);
        cyc(1, 4'h0, 0, 4'b0100, 1);
        chk("t5_cnt_pre", count, 2);
        chk("t5_aidx", alloc_idx, 0);
        chk("t5_didx", d_idx, 2);
        cyc(0, 4'h0, 0, 4'h0, 0);
        chk("t5_cnt", count, 2);
        chk("t5_valid", mshr_valid, 4'b1001);

        // 6: asynchronous reset while the a channel is locked
        cyc(0, 4'b1000, 0, 4'h0, 0);
        chk("t6_locked_v", a_valid, 1);
        chk("t6_locked_i", a_idx, 3);
        #5 rst_n = 1'b0;
        #1 chk_reset_vals("t6");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 4'b1000, 1, 4'h0, 0);
        chk("t6_after", a_valid, 0);

        // randomized traffic, with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1);
        end

        @(posedge clk);
        #1;
        alloc_req = 0; a_req = '0; d_req = '0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_l2_mshr_sched
`default_nettype wire
